ic_pipe: RTL and testbench

- Registered successor to the combinational instruction classifier; sits at the IF/ID → EX boundary of the pipelined MIPS core.
- Accepts one fetched instruction per cycle over a valid/ready handshake and decodes it into a one-hot class vector plus illegal, destination-register and memory/branch flags.
- Holds the result in an output register with pipeline flush.
- Detects load-use hazards and inserts exactly one bubble, counting stalls in a saturating counter.

---
 rtl/ic_pkg.sv | 91 +++++++++
 rtl/ic_decode.sv | 76 +++++++
 rtl/ic_pipe.sv | 147 ++++++++++++++
 tb/tb_ic_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared opcode, function and class-index constants for the
// registered instruction classifier.
package ic_pkg;

    localparam int CLASS_W = 23;

    typedef logic [CLASS_W-1:0] class_t;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_SH      = 6'b101001;
    localparam logic [5:0] OP_SB      = 6'b101000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_BGEZ    = 6'b000001;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_JR      = 6'b001000;

    // Class bit positions in the one-hot vector
    localparam int IC_RTYPE = 0;
    localparam int IC_LUI   = 1;
    localparam int IC_SLTI  = 2;
    localparam int IC_ORI   = 3;
    localparam int IC_XORI  = 4;
    localparam int IC_ADDI  = 5;
    localparam int IC_ADDIU = 6;
    localparam int IC_LW    = 7;
    localparam int IC_SW    = 8;
    localparam int IC_LH    = 9;
    localparam int IC_LHU   = 10;
    localparam int IC_SH    = 11;
    localparam int IC_LB    = 12;
    localparam int IC_LBU   = 13;
    localparam int IC_SB    = 14;
    localparam int IC_BEQ   = 15;
    localparam int IC_BGTZ  = 16;
    localparam int IC_BGEZ  = 17;
    localparam int IC_BNE   = 18;
    localparam int IC_BLEZ  = 19;
    localparam int IC_J     = 20;
    localparam int IC_JAL   = 21;
    localparam int IC_JR    = 22;

    localparam logic [4:0] RA = 5'd31;

    function automatic class_t cbit(input int idx);
        class_t m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Group masks over the class vector
    localparam class_t M_IALU = cbit(IC_LUI) | cbit(IC_SLTI) |
                                cbit(IC_ORI) | cbit(IC_XORI) |
                                cbit(IC_ADDI) | cbit(IC_ADDIU);
    localparam class_t M_LOAD = cbit(IC_LW) | cbit(IC_LH) |
                                cbit(IC_LHU) | cbit(IC_LB) |
                                cbit(IC_LBU);
    localparam class_t M_STORE = cbit(IC_SW) | cbit(IC_SH) |
                                 cbit(IC_SB);
    localparam class_t M_BRANCH = cbit(IC_BEQ) | cbit(IC_BGTZ) |
                                  cbit(IC_BGEZ) | cbit(IC_BNE) |
                                  cbit(IC_BLEZ) | cbit(IC_J) |
                                  cbit(IC_JAL) | cbit(IC_JR);
    // Readers of both rs and rt
    localparam class_t M_RS_RT = cbit(IC_RTYPE) | M_STORE |
                                 cbit(IC_BEQ) | cbit(IC_BNE);
    // Readers of rs only (lui reads nothing)
    localparam class_t M_RS_ONLY = (M_IALU & ~cbit(IC_LUI)) |
                                   M_LOAD | cbit(IC_BGTZ) |
                                   cbit(IC_BLEZ) | cbit(IC_BGEZ) |
                                   cbit(IC_JR);

endpackage

// File: rtl/ic_decode.sv
// Combinational classifier: instruction word -> one-hot class,
// illegal flag, destination, source-use and memory/branch flags.
module ic_decode
    import ic_pkg::*;
(
    input  logic [31:0] inst_i,
    output class_t      class_o,
    output logic        illegal_o,
    output logic [4:0]  dst_o,
    output logic        reads_rs_o,
    output logic        reads_rt_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic        branch_o
);

    logic [5:0] op;
    logic [5:0] fn;
    class_t     cls;
    logic       ill;

    assign op = inst_i[31:26];
    assign fn = inst_i[5:0];

    always_comb begin
        cls = '0;
        ill = 1'b0;
        unique case (op)
            OP_SPECIAL: begin
                if (fn == FN_JR) cls[IC_JR] = 1'b1;
                else             cls[IC_RTYPE] = 1'b1;
            end
            OP_LUI:   cls[IC_LUI]   = 1'b1;
            OP_SLTI:  cls[IC_SLTI]  = 1'b1;
            OP_ORI:   cls[IC_ORI]   = 1'b1;
            OP_XORI:  cls[IC_XORI]  = 1'b1;
            OP_ADDI:  cls[IC_ADDI]  = 1'b1;
            OP_ADDIU: cls[IC_ADDIU] = 1'b1;
            OP_LW:    cls[IC_LW]    = 1'b1;
            OP_LH:    cls[IC_LH]    = 1'b1;
            OP_LHU:   cls[IC_LHU]   = 1'b1;
            OP_LB:    cls[IC_LB]    = 1'b1;
            OP_LBU:   cls[IC_LBU]   = 1'b1;
            OP_SW:    cls[IC_SW]    = 1'b1;
            OP_SH:    cls[IC_SH]    = 1'b1;
            OP_SB:    cls[IC_SB]    = 1'b1;
            OP_BEQ:   cls[IC_BEQ]   = 1'b1;
            OP_BGTZ:  cls[IC_BGTZ]  = 1'b1;
            OP_BGEZ:  cls[IC_BGEZ]  = 1'b1;
            OP_BNE:   cls[IC_BNE]   = 1'b1;
            OP_BLEZ:  cls[IC_BLEZ]  = 1'b1;
            OP_J:     cls[IC_J]     = 1'b1;
            OP_JAL:   cls[IC_JAL]   = 1'b1;
            default:  ill = 1'b1;
        endcase
    end

    always_comb begin
        dst_o = 5'd0;
        if (cls[IC_RTYPE])
            dst_o = inst_i[15:11];
        else if (|(cls & (M_IALU | M_LOAD)))
            dst_o = inst_i[20:16];
        else if (cls[IC_JAL])
            dst_o = RA;
    end

    assign class_o    = cls;
    assign illegal_o  = ill;
    assign reads_rs_o = |(cls & (M_RS_RT | M_RS_ONLY));
    assign reads_rt_o = |(cls & M_RS_RT);
    assign mem_rd_o   = |(cls & M_LOAD);
    assign mem_wr_o   = |(cls & M_STORE);
    assign branch_o   = |(cls & M_BRANCH);

endmodule

// File: rtl/ic_pipe.sv
// Registered instruction classifier at the IF/ID -> EX boundary with
// valid/ready handshake, flush, and one-bubble load-use stall.
// Ports: clk/rst, flush, in_* (fetch side), out_* (EX side), hazard_cnt.
module ic_pipe #(
    parameter int PC_W      = 32,
    parameter int CLASS_W   = 23,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [PC_W-1:0]    out_pc,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_illegal,
    output logic [4:0]         out_dst,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               out_branch,
    output logic [CNT_W-1:0]   hazard_cnt
);

    import ic_pkg::*;

    class_t     dec_class;
    logic       dec_illegal;
    logic [4:0] dec_dst;
    logic       dec_rs;
    logic       dec_rt;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       dec_branch;

    ic_decode u_dec (
        .inst_i     (in_inst),
        .class_o    (dec_class),
        .illegal_o  (dec_illegal),
        .dst_o      (dec_dst),
        .reads_rs_o (dec_rs),
        .reads_rt_o (dec_rt),
        .mem_rd_o   (dec_mem_rd),
        .mem_wr_o   (dec_mem_wr),
        .branch_o   (dec_branch)
    );

    logic               valid_q, valid_d;
    logic [31:0]        inst_q, inst_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic               ill_q, ill_d;
    logic [4:0]         dst_q, dst_d;
    logic               mrd_q, mrd_d;
    logic               mwr_q, mwr_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic dep;
    logic hazard;
    logic accept;

    // Incoming instruction reads the register the held load writes
    assign dep = (dec_rs && (in_inst[25:21] == dst_q)) ||
                 (dec_rt && (in_inst[20:16] == dst_q));

    // Flush discards the input anyway, so no stall is needed then
    assign hazard = HAZARD_EN && !flush && in_valid && valid_q &&
                    out_ready && mrd_q && (dst_q != 5'd0) && dep;

    assign in_ready = !rst && (flush || !valid_q || out_ready) &&
                      !hazard;
    assign accept = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        class_d = class_q;
        ill_d   = ill_q;
        dst_d   = dst_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            inst_d  = in_inst;
            pc_d    = in_pc;
            class_d = dec_class;
            ill_d   = dec_illegal;
            dst_d   = dec_dst;
            mrd_d   = dec_mem_rd;
            mwr_d   = dec_mem_wr;
            br_d    = dec_branch;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (hazard && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
            class_q <= '0;
            ill_q   <= 1'b0;
            dst_q   <= 5'd0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            class_q <= class_d;
            ill_q   <= ill_d;
            dst_q   <= dst_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_pc      = pc_q;
    assign out_class   = class_q;
    assign out_illegal = ill_q;
    assign out_dst     = dst_q;
    assign out_mem_rd  = mrd_q;
    assign out_mem_wr  = mwr_q;
    assign out_branch  = br_q;
    assign hazard_cnt  = cnt_q;

endmodule

// File: tb/tb_ic_pipe.sv
// Directed bench for ic_pipe: decode table vectors plus handshake,
// hazard, flush, hold, saturation and reset sequences.
module tb_ic_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        rdy_m, val_m, ill_m, mrd_m, mwr_m, br_m;
    logic [31:0] inst_m, pc_m;
    logic [22:0] cls_m;
    logic [4:0]  dst_m;
    logic [15:0] cnt_m;

    logic        rdy_n, val_n, ill_n, mrd_n, mwr_n, br_n;
    logic [31:0] inst_n, pc_n;
    logic [22:0] cls_n;
    logic [4:0]  dst_n;
    logic [15:0] cnt_n;

    logic        rdy_c, val_c, ill_c, mrd_c, mwr_c, br_c;
    logic [31:0] inst_c, pc_c;
    logic [22:0] cls_c;
    logic [4:0]  dst_c;
    logic [1:0]  cnt_c;

    always #5 clk = ~clk;

    ic_pipe u_m (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_m),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(val_m), .out_ready(out_ready),
        .out_inst(inst_m), .out_pc(pc_m), .out_class(cls_m),
        .out_illegal(ill_m), .out_dst(dst_m),
        .out_mem_rd(mrd_m), .out_mem_wr(mwr_m),
        .out_branch(br_m), .hazard_cnt(cnt_m)
    );

    ic_pipe #(.HAZARD_EN(1'b0)) u_n (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_n),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(val_n), .out_ready(out_ready),
        .out_inst(inst_n), .out_pc(pc_n), .out_class(cls_n),
        .out_illegal(ill_n), .out_dst(dst_n),
        .out_mem_rd(mrd_n), .out_mem_wr(mwr_n),
        .out_branch(br_n), .hazard_cnt(cnt_n)
    );

    ic_pipe #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_c),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(val_c), .out_ready(out_ready),
        .out_inst(inst_c), .out_pc(pc_c), .out_class(cls_c),
        .out_illegal(ill_c), .out_dst(dst_c),
        .out_mem_rd(mrd_c), .out_mem_wr(mwr_c),
        .out_branch(br_c), .hazard_cnt(cnt_c)
    );

    typedef struct {
        logic [31:0] inst;
        logic [22:0] cls;
        logic        ill;
        logic [4:0]  dst;
        logic        mrd;
        logic        mwr;
        logic        br;
    } vec_t;

    localparam logic [31:0] LW_I  = 32'h8C080000;
    localparam logic [31:0] ADD_I = 32'h01084820;

    vec_t vecs[15];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] b(input int i);
        logic [22:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        vecs[0]  = '{32'h3C011234, b(1),  1'b0, 5'd1,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{ADD_I,        b(0),  1'b0, 5'd9,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{LW_I,         b(7),  1'b0, 5'd8,  1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'hAC080004, b(8),  1'b0, 5'd0,  1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h03E00008, b(22), 1'b0, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h0C000010, b(21), 1'b0, 5'd31, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'h08000010, b(20), 1'b0, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h10220003, b(15), 1'b0, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[8]  = '{32'h04210002, b(17), 1'b0, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h24420001, b(6),  1'b0, 5'd2,  1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h90A30000, b(13), 1'b0, 5'd3,  1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'hA0A30000, b(14), 1'b0, 5'd0,  1'b0, 1'b1, 1'b0};
        vecs[12] = '{32'hFC000000, 23'd0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h28410005, b(2),  1'b0, 5'd1,  1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h84A70000, b(9),  1'b0, 5'd7,  1'b1, 1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_inst = '0; in_pc = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", rdy_m, 1'b0);
        chk("rst_valid", val_m, 1'b0);
        chk("rst_class", cls_m, '0);
        chk("rst_dst", dst_m, '0);
        chk("rst_cnt", cnt_m, '0);
        rst = 1'b0;
        step();

        // Decode table, one instruction at a time
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_inst = vecs[i].inst;
            in_pc = 32'h1000 + 32'(i * 4);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), val_m, 1'b1);
            chk($sformatf("v%0d_inst", i), inst_m, vecs[i].inst);
            chk($sformatf("v%0d_pc", i), pc_m, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d_class", i), cls_m, vecs[i].cls);
            chk($sformatf("v%0d_ill", i), ill_m, vecs[i].ill);
            chk($sformatf("v%0d_dst", i), dst_m, vecs[i].dst);
            chk($sformatf("v%0d_mrd", i), mrd_m, vecs[i].mrd);
            chk($sformatf("v%0d_mwr", i), mwr_m, vecs[i].mwr);
            chk($sformatf("v%0d_br", i), br_m, vecs[i].br);
            step();
            chk($sformatf("v%0d_drain", i), val_m, 1'b0);
        end
        chk("dec_cnt", cnt_m, '0);

        // Load-use pair: one bubble with hazard logic, none without
        in_valid = 1'b1; in_inst = LW_I;
        step();
        in_inst = ADD_I;
        #1;
        chk("hz_in_ready", rdy_m, 1'b0);
        chk("nh_in_ready", rdy_n, 1'b1);
        step();
        chk("hz_bubble", val_m, 1'b0);
        chk("hz_cnt1", cnt_m, 16'd1);
        chk("nh_valid", val_n, 1'b1);
        chk("nh_dst", dst_n, 5'd9);
        chk("nh_cnt", cnt_n, 16'd0);
        chk("hz_ready2", rdy_m, 1'b1);
        step();
        in_valid = 1'b0;
        chk("hz_add_valid", val_m, 1'b1);
        chk("hz_add_dst", dst_m, 5'd9);
        chk("hz_add_class", cls_m, b(0));
        chk("hz_cnt_hold", cnt_m, 16'd1);
        step();

        // Illegal held for three cycles under backpressure
        in_valid = 1'b1; in_inst = 32'hFC000000;
        step();
        in_inst = 32'h3C011234;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_in_ready", rdy_m, 1'b0);
            chk("hold_valid", val_m, 1'b1);
            chk("hold_ill", ill_m, 1'b1);
            chk("hold_class", cls_m, '0);
            chk("hold_inst", inst_m, 32'hFC000000);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold_release", val_m, 1'b0);

        // Flush while a load is held and a dependent add is offered
        in_valid = 1'b1; in_inst = LW_I;
        step();
        in_inst = ADD_I;
        flush = 1'b1;
        #1;
        chk("fl_in_ready", rdy_m, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", val_m, 1'b0);
        chk("fl_cnt", cnt_m, 16'd1);
        chk("fl_keep_inst", inst_m, LW_I);
        chk("fl_keep_dst", dst_m, 5'd8);
        step();
        chk("fl_dropped", val_m, 1'b0);

        // Four more hazards; the 2-bit counter pins at 3
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_inst = LW_I;
            step();
            in_inst = ADD_I;
            step();
            step();
            in_valid = 1'b0;
            chk($sformatf("sat%0d_main", k), cnt_m, 16'(1 + k));
            chk($sformatf("sat%0d_c2", k), cnt_c, (k >= 2) ? 2'd3 : 2'(1 + k));
            step();
        end

        // Back-to-back independent accepts at full throughput
        in_valid = 1'b1; in_inst = 32'h3C011234;
        step();
        in_inst = 32'h24420001;
        #1;
        chk("tp_ready", rdy_m, 1'b1);
        step();
        in_valid = 1'b0;
        chk("tp_valid", val_m, 1'b1);
        chk("tp_class", cls_m, b(6));
        chk("tp_dst", dst_m, 5'd2);
        step();

        // Reset during a stall drops the pending add
        in_valid = 1'b1; in_inst = LW_I;
        step();
        in_inst = ADD_I;
        rst = 1'b1;
        step();
        chk("rs_valid", val_m, 1'b0);
        chk("rs_cnt", cnt_m, '0);
        chk("rs_cnt_c2", cnt_c, '0);
        chk("rs_ready", rdy_m, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("rs_after", val_m, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
